// File: rtl/spi_host_ctrl.sv
// SPI host controller: frames a {cmd, wdata} request onto SS_n/MOSI, one bit
// per clk, and for read-data requests (cmd 2'b11) shifts an 8-bit reply in
// from MISO. The clock is shared with the slave, so no SCLK is generated.
module spi_host_ctrl #(
  parameter int CMD_SETUP = 1,
  parameter int READ_WAIT = 2,
  parameter int IDLE_GAP  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       MOSI,
  output logic       SS_n,
  input  logic       MISO
);

  localparam int FRAME_BITS = 10;
  localparam int RX_BITS    = 8;

  // One down-counter serves every timed state, so it is sized for the longest.
  localparam int MAX_SR  = (CMD_SETUP > READ_WAIT) ? CMD_SETUP : READ_WAIT;
  localparam int MAX_SG  = (MAX_SR > IDLE_GAP) ? MAX_SR : IDLE_GAP;
  localparam int MAX_CNT = (MAX_SG > FRAME_BITS) ? MAX_SG : FRAME_BITS;
  localparam int CW      = $clog2(MAX_CNT);

  localparam logic [CW-1:0] SETUP_LOAD = CW'((CMD_SETUP > 0) ? CMD_SETUP - 1 : 0);
  localparam logic [CW-1:0] WAIT_LOAD  = CW'((READ_WAIT > 0) ? READ_WAIT - 1 : 0);
  localparam logic [CW-1:0] GAP_LOAD   = CW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
  localparam logic [CW-1:0] OUT_LOAD   = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] IN_LOAD    = CW'(RX_BITS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SETUP     = 3'd1;
  localparam logic [2:0] S_SHIFT_OUT = 3'd2;
  localparam logic [2:0] S_WAIT      = 3'd3;
  localparam logic [2:0] S_SHIFT_IN  = 3'd4;
  localparam logic [2:0] S_FINISH    = 3'd5;
  localparam logic [2:0] S_GAP       = 3'd6;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [9:0]    frame_sr;
  logic          is_read;
  logic [6:0]    rx_sr;

  // Frame sequencer: latches the request, walks the phases, collects the reply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      frame_sr <= '0;
      is_read  <= 1'b0;
      rx_sr    <= '0;
      rdata    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            frame_sr <= {cmd, wdata};
            is_read  <= (cmd == 2'b11);
            if (CMD_SETUP > 0) begin
              state <= S_SETUP;
              cnt   <= SETUP_LOAD;
            end else begin
              state <= S_SHIFT_OUT;
              cnt   <= OUT_LOAD;
            end
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            state <= S_SHIFT_OUT;
            cnt   <= OUT_LOAD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_SHIFT_OUT: begin
          frame_sr <= {frame_sr[8:0], 1'b0};
          if (cnt == '0) begin
            if (!is_read) begin
              state <= S_FINISH;
            end else if (READ_WAIT > 0) begin
              state <= S_WAIT;
              cnt   <= WAIT_LOAD;
            end else begin
              state <= S_SHIFT_IN;
              cnt   <= IN_LOAD;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state <= S_SHIFT_IN;
            cnt   <= IN_LOAD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_SHIFT_IN: begin
          rx_sr <= {rx_sr[5:0], MISO};
          if (cnt == '0) begin
            rdata <= {rx_sr, MISO};
            state <= S_FINISH;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_FINISH: begin
          if (IDLE_GAP > 0) begin
            state <= S_GAP;
            cnt   <= GAP_LOAD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state, so an async reset releases SS_n at once.
  assign SS_n        = !(state inside {S_SETUP, S_SHIFT_OUT, S_WAIT, S_SHIFT_IN});
  assign MOSI        = (state == S_SHIFT_OUT) && frame_sr[9];
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_FINISH);
  assign rdata_valid = (state == S_FINISH) && is_read;

endmodule

// File: tb/tb_spi_host_ctrl.sv
// Self-checking bench for spi_host_ctrl: a default instance plus a second one
// with CMD_SETUP=2, READ_WAIT=0, IDLE_GAP=0, driven from a vector table and a
// few hand-written multi-cycle sequences.
module tb_spi_host_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       start2;
  logic [1:0] cmd;
  logic [7:0] wdata;
  logic       miso;

  logic       busy1, done1, rv1, mosi1, ss1;
  logic [7:0] rdata1;
  logic       busy2, done2, rv2, mosi2, ss2;
  logic [7:0] rdata2;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    bit         use2;
    logic [1:0] cmd;
    logic [7:0] wdata;
    logic [7:0] miso_byte;
    int         exp_low;
    logic [9:0] exp_mosi;
    int         exp_rv;
    logic [7:0] exp_rdata;
    int         exp_gap;
  } vec_t;

  vec_t vecs [7];

  spi_host_ctrl dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .wdata(wdata),
    .busy(busy1), .done(done1), .rdata(rdata1), .rdata_valid(rv1),
    .MOSI(mosi1), .SS_n(ss1), .MISO(miso)
  );

  spi_host_ctrl #(.CMD_SETUP(2), .READ_WAIT(0), .IDLE_GAP(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .cmd(cmd), .wdata(wdata),
    .busy(busy2), .done(done2), .rdata(rdata2), .rdata_valid(rv2),
    .MOSI(mosi2), .SS_n(ss2), .MISO(miso)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic sample(input bit use2, output logic s_ss, output logic s_mosi,
                        output logic s_busy, output logic s_done, output logic s_rv,
                        output logic [7:0] s_rd);
    s_ss   = use2 ? ss2    : ss1;
    s_mosi = use2 ? mosi2  : mosi1;
    s_busy = use2 ? busy2  : busy1;
    s_done = use2 ? done2  : done1;
    s_rv   = use2 ? rv2    : rv1;
    s_rd   = use2 ? rdata2 : rdata1;
  endtask

  // Runs one frame from a negedge with busy=0, acting as the slave on MISO,
  // and compares the observed frame against the vector. inject_at >= 0 pulses
  // a competing cmd=11 start on dut1 at that cycle of the frame.
  task automatic applyStimulus(input vec_t v, input int inject_at, input string tag);
    int         setup;
    int         s0;
    int         low;
    int         dones;
    int         rvs;
    int         gapc;
    logic [9:0] mbits;
    logic       zero_ok;
    logic [7:0] rd_at_done;
    bit         timed_out;
    logic       s_ss, s_mosi, s_busy, s_done, s_rv;
    logic [7:0] s_rd;
    setup      = v.use2 ? 2 : 1;
    s0         = setup + 10 + (v.use2 ? 0 : 2);
    low        = 0;
    dones      = 0;
    rvs        = 0;
    gapc       = 0;
    mbits      = '0;
    zero_ok    = 1'b1;
    rd_at_done = 8'h00;
    timed_out  = 1'b1;
    cmd        = v.cmd;
    wdata      = v.wdata;
    if (v.use2) start2 = 1'b1;
    else        start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
    for (int k = 0; k < 100; k++) begin
      sample(v.use2, s_ss, s_mosi, s_busy, s_done, s_rv, s_rd);
      if (k == inject_at) begin
        start = 1'b1;
        cmd   = 2'b11;
        wdata = 8'hFF;
      end else begin
        start = 1'b0;
      end
      miso = 1'b1;
      if (!s_ss) begin
        if (low >= setup && low < setup + 10) mbits[9 - (low - setup)] = s_mosi;
        else if (s_mosi) zero_ok = 1'b0;
        if (low >= s0 && low < s0 + 8) miso = v.miso_byte[7 - (low - s0)];
        low++;
      end
      if (s_done) begin
        dones++;
        rd_at_done = s_rd;
      end
      if (s_rv) rvs++;
      if (dones > 0 && !s_done && s_busy) gapc++;
      if (dones > 0 && !s_busy) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    miso  = 1'b1;
    checkOutput({tag, " timeout"},   32'(timed_out), 32'd0);
    checkOutput({tag, " ss_low"},    32'(low), 32'(v.exp_low));
    checkOutput({tag, " mosi"},      32'(mbits), 32'(v.exp_mosi));
    checkOutput({tag, " mosi_zero"}, 32'(zero_ok), 32'd1);
    checkOutput({tag, " done"},      32'(dones), 32'd1);
    checkOutput({tag, " rvalid"},    32'(rvs), 32'(v.exp_rv));
    checkOutput({tag, " rdata"},     32'(rd_at_done), 32'(v.exp_rdata));
    checkOutput({tag, " gap"},       32'(gapc), 32'(v.exp_gap));
  endtask

  initial begin
    logic ss_h   [60];
    logic busy_h [60];
    logic mosi_h [60];
    int   l0, h0, b0, l1, n_done;
    vec_t v_inj;

    // use2, cmd, wdata, miso_byte, exp_low, exp_mosi, exp_rv, exp_rdata, exp_gap
    vecs[0] = '{1'b0, 2'b00, 8'hA5, 8'h00, 11, 10'h0A5, 0, 8'h00, 1};
    vecs[1] = '{1'b0, 2'b11, 8'h00, 8'h3C, 21, 10'h300, 1, 8'h3C, 1};
    vecs[2] = '{1'b0, 2'b01, 8'h5A, 8'h00, 11, 10'h15A, 0, 8'h3C, 1};
    vecs[3] = '{1'b0, 2'b10, 8'hC3, 8'hFF, 11, 10'h2C3, 0, 8'h3C, 1};
    vecs[4] = '{1'b0, 2'b11, 8'hFF, 8'h81, 21, 10'h3FF, 1, 8'h81, 1};
    vecs[5] = '{1'b1, 2'b11, 8'h42, 8'hA6, 20, 10'h342, 1, 8'hA6, 0};
    vecs[6] = '{1'b1, 2'b01, 8'h3C, 8'h00, 12, 10'h13C, 0, 8'hA6, 0};
    v_inj   = '{1'b0, 2'b01, 8'h96, 8'h00, 11, 10'h196, 0, 8'h81, 1};

    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    cmd    = 2'b00;
    wdata  = 8'h00;
    miso   = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset ss_n",  32'(ss1), 32'd1);
    checkOutput("reset mosi",  32'(mosi1), 32'd0);
    checkOutput("reset busy",  32'(busy1), 32'd0);
    checkOutput("reset done",  32'(done1), 32'd0);
    checkOutput("reset rv",    32'(rv1), 32'd0);
    checkOutput("reset rdata", 32'(rdata1), 32'd0);
    checkOutput("reset ss_n2", 32'(ss2), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], -1, $sformatf("vec%0d", i));

    // Start held high with cmd alternating 01/10 at each done.
    cmd   = 2'b01;
    wdata = 8'h33;
    start = 1'b1;
    @(negedge clk);
    n_done = 0;
    for (int i = 0; i < 60; i++) begin
      ss_h[i]   = ss1;
      busy_h[i] = busy1;
      mosi_h[i] = mosi1;
      if (done1) begin
        n_done++;
        cmd = (cmd == 2'b01) ? 2'b10 : 2'b01;
      end
      @(negedge clk);
    end
    start = 1'b0;
    l0 = 0;
    while (l0 < 60 && !ss_h[l0]) l0++;
    h0 = 0;
    while (l0 + h0 < 60 && ss_h[l0 + h0]) h0++;
    b0 = l0 + h0;
    l1 = 0;
    while (b0 + l1 < 60 && !ss_h[b0 + l1]) l1++;
    if (b0 < 3 || b0 > 55) b0 = 3;
    checkOutput("b2b first_len",  32'(l0), 32'd11);
    checkOutput("b2b high_run",   32'(h0), 32'd3);
    checkOutput("b2b second_len", 32'(l1), 32'd11);
    checkOutput("b2b busy_before_gap", 32'(busy_h[b0 - 2]), 32'd1);
    checkOutput("b2b busy_at_accept",  32'(busy_h[b0 - 1]), 32'd0);
    checkOutput("b2b first_cmd",  32'({mosi_h[1], mosi_h[2]}), 32'd1);
    checkOutput("b2b second_cmd", 32'({mosi_h[b0 + 1], mosi_h[b0 + 2]}), 32'd2);
    checkOutput("b2b done_count", 32'(n_done), 32'd4);
    for (int i = 0; i < 40 && busy1; i++) @(negedge clk);
    checkOutput("b2b drain", 32'(busy1), 32'd0);

    // A cmd=11 start during a cmd=01 frame must leave that frame untouched.
    applyStimulus(v_inj, 4, "inject");
    repeat (3) @(negedge clk);
    checkOutput("inject no_new_frame", 32'({ss1, busy1}), 32'h2);

    // Reset in the middle of SHIFT_IN bit 4 of a read-data frame.
    cmd   = 2'b11;
    wdata = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    checkOutput("midreset pre ss_n", 32'(ss1), 32'd0);
    checkOutput("midreset pre busy", 32'(busy1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset ss_n",  32'(ss1), 32'd1);
    checkOutput("midreset busy",  32'(busy1), 32'd0);
    checkOutput("midreset done",  32'(done1), 32'd0);
    checkOutput("midreset rdata", 32'(rdata1), 32'd0);
    @(negedge clk);
    checkOutput("midreset done_later", 32'(done1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(vecs[0], -1, "postreset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
